// File: rtl/fpu_pkg.sv
// Shared types for the FP divide request path.
// Holds the fp32 type, the canonical qNaN and the request FSM states.
package fpu_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_QNAN = 32'hFFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } req_state_e;

endpackage

// File: rtl/fpu_sat_cnt.sv
// Saturating event counter with synchronous clear.
// Ports: clk, clr (sync clear), inc (count enable), cnt (value).
module fpu_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fpu_div_req.sv
// Divide request initiator: core req/rsp channels to the FP unit's
// dval/rdy strobe protocol, with timeout and saturating statistics.
// Ports: req_* (core request), rsp_* (core response), fpu_* (unit side),
// stat_* (done / timeout / spurious-rdy counters), clk, rst (sync, high).
module fpu_div_req
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp32_t            req_a,
  input  fp32_t            req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output fp32_t            rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output fp32_t            fpu_din1,
  output fp32_t            fpu_din2,
  output logic             fpu_dval,
  input  fp32_t            fpu_result,
  input  logic             fpu_rdy,
  output logic [CNT_W-1:0] stat_done,
  output logic [CNT_W-1:0] stat_timeout,
  output logic [CNT_W-1:0] stat_spurious
);

  localparam int WC_W = $clog2(TIMEOUT_CYC);
  localparam logic [WC_W-1:0] WC_LAST =
    WC_W'(TIMEOUT_CYC - 1);

  req_state_e       state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             req_ready_d;
  logic             rsp_valid_d;
  fp32_t            rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_d;
  logic             rsp_timeout_d;
  fp32_t            din1_d, din2_d;
  logic             dval_d;

  logic in_wait, done_inc, tmo_inc, spur_inc;

  assign in_wait  = (state_q == WAIT);
  assign done_inc = in_wait && fpu_rdy;
  assign tmo_inc  = in_wait && !fpu_rdy
                 && (wcnt_q == WC_LAST);
  // Covers late results after a timeout or reset.
  assign spur_inc = fpu_rdy && !in_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_timeout <= 1'b0;
      fpu_din1    <= '0;
      fpu_din2    <= '0;
      fpu_dval    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_tag     <= rsp_tag_d;
      rsp_timeout <= rsp_timeout_d;
      fpu_din1    <= din1_d;
      fpu_din2    <= din2_d;
      fpu_dval    <= dval_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_data_d    = rsp_data;
    rsp_tag_d     = rsp_tag;
    rsp_timeout_d = rsp_timeout;
    din1_d        = fpu_din1;
    din2_d        = fpu_din2;
    dval_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          din1_d      = req_a;
          din2_d      = req_b;
          rsp_tag_d   = req_tag;
          req_ready_d = 1'b0;
          dval_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result on the last wait cycle still wins.
        if (fpu_rdy) begin
          rsp_data_d    = fpu_result;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (wcnt_q == WC_LAST) begin
          rsp_data_d    = FP32_QNAN;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fpu_sat_cnt #(.W(CNT_W)) u_done (
    .clk (clk),
    .clr (rst),
    .inc (done_inc),
    .cnt (stat_done)
  );

  fpu_sat_cnt #(.W(CNT_W)) u_tmo (
    .clk (clk),
    .clr (rst),
    .inc (tmo_inc),
    .cnt (stat_timeout)
  );

  fpu_sat_cnt #(.W(CNT_W)) u_spur (
    .clk (clk),
    .clr (rst),
    .inc (spur_inc),
    .cnt (stat_spurious)
  );

endmodule

// File: tb/tb_fpu_div_req.sv
// Bench for fpu_div_req: two instances (default and short-timeout,
// 2-bit counters) against a cycle-timestamp model plus directed checks.
module tb_fpu_div_req;

  localparam int TO[2]   = '{255, 16};
  localparam int MAXC[2] = '{65535, 3};

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [3:0]  req_tag [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data [2];
  logic [3:0]  rsp_tag [2];
  logic        rsp_timeout [2];
  logic [31:0] din1 [2];
  logic [31:0] din2 [2];
  logic        dval [2];
  logic [31:0] result [2];
  logic        rdy [2];
  logic [15:0] st0_done, st0_tmo, st0_sp;
  logic [1:0]  st1_done, st1_tmo, st1_sp;

  always #5 clk = ~clk;

  fpu_div_req #(
    .TIMEOUT_CYC(255), .TAG_W(4), .CNT_W(16)
  ) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_tag(rsp_tag[0]),
    .rsp_timeout(rsp_timeout[0]),
    .fpu_din1(din1[0]), .fpu_din2(din2[0]), .fpu_dval(dval[0]),
    .fpu_result(result[0]), .fpu_rdy(rdy[0]),
    .stat_done(st0_done), .stat_timeout(st0_tmo),
    .stat_spurious(st0_sp)
  );

  fpu_div_req #(
    .TIMEOUT_CYC(16), .TAG_W(4), .CNT_W(2)
  ) u1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_tag(rsp_tag[1]),
    .rsp_timeout(rsp_timeout[1]),
    .fpu_din1(din1[1]), .fpu_din2(din2[1]), .fpu_dval(dval[1]),
    .fpu_result(result[1]), .fpu_rdy(rdy[1]),
    .stat_done(st1_done), .stat_timeout(st1_tmo),
    .stat_spurious(st1_sp)
  );

  function automatic logic [31:0] s_done(input int d);
    return (d == 0) ? 32'(st0_done) : 32'(st1_done);
  endfunction
  function automatic logic [31:0] s_tmo(input int d);
    return (d == 0) ? 32'(st0_tmo) : 32'(st1_tmo);
  endfunction
  function automatic logic [31:0] s_sp(input int d);
    return (d == 0) ? 32'(st0_sp) : 32'(st1_sp);
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // Model: cycle timestamps. acc = request handshake cycle;
  // dval at acc+1, waiting over acc+2 .. acc+1+TO.
  int          cyc = 0;
  int          m_acc [2];
  bit          m_res [2];
  logic        m_ready [2];
  logic        m_vld [2];
  logic        m_dval [2];
  logic        m_to [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_tag [2];
  logic [31:0] m_d1 [2];
  logic [31:0] m_d2 [2];
  int          m_done [2];
  int          m_tmo [2];
  int          m_sp [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_acc[d] <= -1;  m_res[d] <= 1'b0;
        m_ready[d] <= 1'b1; m_vld[d] <= 1'b0;
        m_dval[d] <= 1'b0; m_to[d] <= 1'b0;
        m_data[d] <= '0; m_tag[d] <= '0;
        m_d1[d] <= '0; m_d2[d] <= '0;
        m_done[d] <= 0; m_tmo[d] <= 0; m_sp[d] <= 0;
      end else begin
        m_dval[d] <= 1'b0;
        if (rdy[d] && !(m_acc[d] >= 0 && !m_res[d]
                        && cyc >= m_acc[d] + 2))
          if (m_sp[d] < MAXC[d]) m_sp[d] <= m_sp[d] + 1;
        if (m_ready[d] && req_valid[d]) begin
          m_acc[d] <= cyc; m_res[d] <= 1'b0;
          m_ready[d] <= 1'b0; m_dval[d] <= 1'b1;
          m_d1[d] <= req_a[d]; m_d2[d] <= req_b[d];
          m_tag[d] <= req_tag[d];
        end else if (m_acc[d] >= 0 && !m_res[d]
                     && cyc >= m_acc[d] + 2) begin
          if (rdy[d]) begin
            m_res[d] <= 1'b1; m_vld[d] <= 1'b1;
            m_data[d] <= result[d]; m_to[d] <= 1'b0;
            if (m_done[d] < MAXC[d]) m_done[d] <= m_done[d] + 1;
          end else if (cyc == m_acc[d] + 1 + TO[d]) begin
            m_res[d] <= 1'b1; m_vld[d] <= 1'b1;
            m_data[d] <= 32'hFFC0_0000; m_to[d] <= 1'b1;
            if (m_tmo[d] < MAXC[d]) m_tmo[d] <= m_tmo[d] + 1;
          end
        end else if (m_vld[d] && rsp_ready[d]) begin
          m_vld[d] <= 1'b0; m_ready[d] <= 1'b1;
          m_acc[d] <= -1;
        end
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 2) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("u%0d.req_ready", d),
            32'(req_ready[d]), 32'(m_ready[d]));
        chk($sformatf("u%0d.rsp_valid", d),
            32'(rsp_valid[d]), 32'(m_vld[d]));
        chk($sformatf("u%0d.fpu_dval", d),
            32'(dval[d]), 32'(m_dval[d]));
        chk($sformatf("u%0d.fpu_din1", d), din1[d], m_d1[d]);
        chk($sformatf("u%0d.fpu_din2", d), din2[d], m_d2[d]);
        chk($sformatf("u%0d.stat_done", d), s_done(d), m_done[d]);
        chk($sformatf("u%0d.stat_timeout", d), s_tmo(d), m_tmo[d]);
        chk($sformatf("u%0d.stat_spurious", d), s_sp(d), m_sp[d]);
        if (m_vld[d]) begin
          chk($sformatf("u%0d.rsp_data", d), rsp_data[d], m_data[d]);
          chk($sformatf("u%0d.rsp_tag", d),
              32'(rsp_tag[d]), 32'(m_tag[d]));
          chk($sformatf("u%0d.rsp_timeout", d),
              32'(rsp_timeout[d]), 32'(m_to[d]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int d, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tg,
                      output int hs);
    int n;
    n = 0;
    req_a[d] = a; req_b[d] = b; req_tag[d] = tg;
    req_valid[d] = 1'b1;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      tick(); n++;
    end
    if (n >= 50) chk("send_ready_bound", 32'(req_ready[d]), 1);
    hs = cyc;
    tick();
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_dval(input int d, output int c);
    int n;
    n = 0;
    while (dval[d] !== 1'b1 && n < 20) begin
      tick(); n++;
    end
    if (n >= 20) chk("dval_bound", 32'(dval[d]), 1);
    c = cyc;
  endtask

  task automatic pulse_at(input int d, input int c,
                          input logic [31:0] r);
    while (cyc < c) tick();
    rdy[d] = 1'b1; result[d] = r;
    tick();
    rdy[d] = 1'b0; result[d] = '0;
  endtask

  task automatic wait_rsp(input int d, output int c);
    int n;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 300) begin
      tick(); n++;
    end
    if (n >= 300) chk("rsp_bound", 32'(rsp_valid[d]), 1);
    c = cyc;
  endtask

  task automatic drain(input int d);
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
  endtask

  task automatic reset1();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int hs, dc, rc, h;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0;
      req_a[d] = '0; req_b[d] = '0; req_tag[d] = '0;
      rsp_ready[d] = 1'b0; rdy[d] = 1'b0; result[d] = '0;
    end
    tick_n(3);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Reset state
    chk("rst_req_ready", 32'(req_ready[0]), 1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_dval", 32'(dval[0]), 0);
    chk("rst_din1", din1[0], 0);
    chk("rst_stat_done", s_done(0), 0);

    // 1: 6.0 / 2.0, tag 3, result 60 cycles after dval
    send(0, 32'h40C0_0000, 32'h4000_0000, 4'd3, hs);
    wait_dval(0, dc);
    chk("t1_dval_latency", dc, hs + 1);
    chk("t1_din1", din1[0], 32'h40C0_0000);
    tick();
    chk("t1_dval_one_cycle", 32'(dval[0]), 0);
    pulse_at(0, dc + 60, 32'h4040_0000);
    chk("t1_rsp_valid", 32'(rsp_valid[0]), 1);
    chk("t1_rsp_data", rsp_data[0], 32'h4040_0000);
    chk("t1_rsp_tag", 32'(rsp_tag[0]), 3);
    chk("t1_rsp_timeout", 32'(rsp_timeout[0]), 0);
    chk("t1_stat_done", s_done(0), 1);
    drain(0);
    chk("t1_rsp_cleared", 32'(rsp_valid[0]), 0);
    chk("t1_ready_back", 32'(req_ready[0]), 1);

    // 2: backpressure, second request waiting throughout
    send(0, 32'h40A0_0000, 32'h4000_0000, 4'd5, hs);
    wait_dval(0, dc);
    pulse_at(0, dc + 3, 32'h4020_0000);
    req_valid[0] = 1'b1; req_a[0] = 32'h4100_0000;
    req_b[0] = 32'h4080_0000; req_tag[0] = 4'd6;
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_data", rsp_data[0], 32'h4020_0000);
      chk("t2_hold_tag", 32'(rsp_tag[0]), 5);
      chk("t2_no_ready", 32'(req_ready[0]), 0);
      tick();
    end
    rsp_ready[0] = 1'b1;
    chk("t2_ready_at_hs", 32'(req_ready[0]), 0);
    tick();
    rsp_ready[0] = 1'b0;
    h = cyc;
    chk("t2_ready_after_hs", 32'(req_ready[0]), 1);
    tick();
    req_valid[0] = 1'b0;
    chk("t2_second_dval", 32'(dval[0]), 1);
    chk("t2_second_dval_cyc", cyc, h + 1);
    chk("t2_second_din1", din1[0], 32'h4100_0000);
    pulse_at(0, cyc + 2, 32'h4000_0000);
    wait_rsp(0, rc);
    chk("t2_second_data", rsp_data[0], 32'h4000_0000);
    chk("t2_second_tag", 32'(rsp_tag[0]), 6);
    drain(0);
    chk("t2_stat_done", s_done(0), 3);

    // 3: timeout with TIMEOUT_CYC=16
    send(1, 32'h4120_0000, 32'h0000_0000, 4'd7, hs);
    wait_dval(1, dc);
    wait_rsp(1, rc);
    chk("t3_wait_cycles", rc - dc - 1, 16);
    chk("t3_rsp_data", rsp_data[1], 32'hFFC0_0000);
    chk("t3_rsp_timeout", 32'(rsp_timeout[1]), 1);
    chk("t3_rsp_tag", 32'(rsp_tag[1]), 7);
    chk("t3_stat_timeout", s_tmo(1), 1);
    chk("t3_stat_done", s_done(1), 0);
    drain(1);
    tick();
    pulse_at(1, cyc, 32'h4120_0000);
    chk("t3_spurious", s_sp(1), 1);
    chk("t3_no_rsp", 32'(rsp_valid[1]), 0);
    tick_n(3);
    chk("t3_still_no_rsp", 32'(rsp_valid[1]), 0);

    // 4: rdy on the 16th wait cycle beats the timeout
    reset1();
    send(1, 32'h3F80_0000, 32'h3F80_0000, 4'd8, hs);
    wait_dval(1, dc);
    pulse_at(1, dc + 16, 32'h3F80_0000);
    chk("t4_rsp_valid", 32'(rsp_valid[1]), 1);
    chk("t4_rsp_data", rsp_data[1], 32'h3F80_0000);
    chk("t4_rsp_timeout", 32'(rsp_timeout[1]), 0);
    chk("t4_stat_timeout", s_tmo(1), 0);
    chk("t4_stat_done", s_done(1), 1);
    drain(1);

    // 5: reset during WAIT
    send(1, 32'h4040_0000, 32'h3F80_0000, 4'd9, hs);
    wait_dval(1, dc);
    tick_n(3);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("t5_req_ready", 32'(req_ready[1]), 1);
    chk("t5_rsp_valid", 32'(rsp_valid[1]), 0);
    chk("t5_stat_done", s_done(1), 0);
    chk("t5_stat_spur0", s_sp(1), 0);
    pulse_at(1, cyc + 2, 32'h4040_0000);
    chk("t5_spurious", s_sp(1), 1);
    chk("t5_no_rsp", 32'(rsp_valid[1]), 0);

    // 6: 2-bit done counter saturates
    reset1();
    for (int k = 0; k < 5; k++) begin
      send(1, 32'h4000_0000, 32'h3F80_0000, 4'(k), hs);
      wait_dval(1, dc);
      pulse_at(1, dc + 1, 32'h4000_0000);
      wait_rsp(1, rc);
      drain(1);
    end
    chk("t6_stat_done_sat", s_done(1), 3);

    tick_n(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_div_req.md
Name: fpu_div_req

Overview:
Initiator for the FP unit's single-cycle dval / one-cycle rdy operand protocol, used here to drive the single-precision divider.
- Accepts divide requests from the core on a valid/ready channel.
- Issues each request to the unit, waits for the result and detects timeouts.
- Returns the result with its tag on a valid/ready response channel.
- Sits between the RISC-V core FP dispatch and the divider; one operation in flight at a time.

Parameters:
TIMEOUT_CYC, 255, maximum cycles in WAIT without fpu_rdy before the operation is aborted (legal range 2..65535).
TAG_W, 4, width of the request/response tag.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is synchronous and active-high
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request
req_a  in  32  dividend, IEEE-754 single
req_b  in  32  divisor, IEEE-754 single
req_tag  in  TAG_W  request identifier
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_data  out  32  quotient, or qNaN on timeout
rsp_tag  out  TAG_W  tag of the completed request
rsp_timeout  out  1  response produced by timeout
fpu_din1  out  32  operand 1 to unit
fpu_din2  out  32  operand 2 to unit
fpu_dval  out  1  one-cycle issue strobe to unit
fpu_result  in  32  unit result, valid when fpu_rdy=1
fpu_rdy  in  1  one-cycle result strobe from unit
stat_done  out  CNT_W  completed operations, saturating
stat_timeout  out  CNT_W  timed-out operations, saturating
stat_spurious  out  CNT_W  fpu_rdy seen outside WAIT, saturating

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - state=IDLE; req_ready=1.
  - rsp_valid=0, rsp_timeout=0, fpu_dval=0.
  - rsp_data, rsp_tag, fpu_din1, fpu_din2 = 0.
  - All stat counters = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a→fpu_din1, req_b→fpu_din2, req_tag; go to ISSUE.
- ISSUE:
  - fpu_dval=1 for exactly this one cycle, with fpu_din1/2 stable.
  - Clear wait_cnt; go to WAIT.
- WAIT:
  - fpu_dval=0; fpu_din1/2 held.
  - fpu_rdy=1: capture fpu_result→rsp_data, rsp_timeout=0, stat_done+1, go to RESP.
  - Else if wait_cnt==TIMEOUT_CYC-1: rsp_data=32'hFFC00000, rsp_timeout=1, stat_timeout+1, go to RESP.
  - Else: wait_cnt+1.
  - At most TIMEOUT_CYC cycles spent in WAIT.
  - fpu_rdy and the timeout in the same cycle: fpu_rdy wins (normal completion).
- RESP:
  - rsp_valid=1; rsp_data, rsp_tag, rsp_timeout held stable until rsp_valid&rsp_ready.
  - On that handshake: rsp_valid=0 next cycle, go to IDLE.
  - No combinational path from rsp_ready to req_ready: the next request is accepted no earlier than the cycle after the response handshake.
- Latency (req handshake at cycle N):
  - fpu_dval at N+1.
  - fpu_rdy at cycle M gives rsp_valid at M+1.
- fpu_rdy seen in IDLE, ISSUE or RESP: ignored for data, stat_spurious+1. This covers a late result after a timeout.
- req_valid outside IDLE: ignored, since req_ready=0.
- Reset mid-operation:
  - Returns to IDLE immediately; no response is emitted for the aborted tag.
  - The unit may still be busy; its eventual fpu_rdy counts as spurious.
- Statistics counters saturate at all-ones; they never wrap.
- wait_cnt width is $clog2(TIMEOUT_CYC).
- All outputs are registered.

Decomposition:
- Shared package fpu_pkg holds:
  - FP32_QNAN = 32'hFFC00000.
  - The req-state enum typedef (IDLE/ISSUE/WAIT/RESP).
  - An fp32_t typedef.
- One natural sub-module: fpu_sat_cnt (parameterised width, inc input, synchronous clear), instantiated three times.
- The FSM stays in fpu_div_req.

Test Plan:
1. Divide 6.0/2.0, tag 3:
   - Stimulus: req_a=40C00000, req_b=40000000; unit model gives fpu_rdy 60 cycles after fpu_dval with fpu_result=40400000.
   - Required: fpu_dval high one cycle at N+1; rsp_valid at rdy+1 with rsp_data=40400000, rsp_tag=3, rsp_timeout=0; stat_done=1.
2. Backpressure:
   - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid.
   - Required: rsp_data/tag stable throughout; req_ready=0; second request accepted only the cycle after the handshake.
3. Timeout, TIMEOUT_CYC=16, model never asserts fpu_rdy:
   - Required: exactly 16 WAIT cycles, then rsp_data=FFC00000, rsp_timeout=1; stat_timeout=1.
   - Follow-up: a later fpu_rdy in IDLE gives stat_spurious=1 and no response.
4. Coincident timeout:
   - Stimulus: fpu_rdy on the 16th WAIT cycle (TIMEOUT_CYC=16) with result 3F800000.
   - Required: rsp_data=3F800000, rsp_timeout=0, stat_timeout=0.
5. Reset mid-operation:
   - Stimulus: rst pulsed during WAIT.
   - Required: next cycle req_ready=1, rsp_valid=0, counters=0; later fpu_rdy gives stat_spurious=1.
6. Saturation, CNT_W=2:
   - Stimulus: 5 back-to-back completions.
   - Required: stat_done=3.
